// File: rtl/control_fsm_8085_multi_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pkg_8085_multi
//  Brief    : Shared opcode map, funct codes, mux selectors, state and class
//             encodings for the 8085-style multi-cycle core.
//  Revision : 1.0  initial release
// ============================================================================
package pkg_8085_multi;

  // Opcode map
  localparam logic [4:0] OP_RALU_HI = 5'h03;  // 0x00..0x03 register ALU
  localparam logic [4:0] OP_RLOG    = 5'h04;
  localparam logic [4:0] OP_ADI     = 5'h05;  // first ALU-immediate opcode
  localparam logic [4:0] OP_IMM_HI  = 5'h0B;  // last ALU-immediate opcode
  localparam logic [4:0] OP_CPI     = 5'h0C;
  localparam logic [4:0] OP_LDA     = 5'h0F;
  localparam logic [4:0] OP_STA     = 5'h10;
  localparam logic [4:0] OP_JMP     = 5'h11;
  localparam logic [4:0] OP_JZ      = 5'h12;
  localparam logic [4:0] OP_HLT     = 5'h1F;

  // Funct codes
  localparam logic [4:0] FN_ALU_MAX = 5'h09;
  localparam logic [4:0] FN_AND     = 5'h0A;
  localparam logic [4:0] FN_OR      = 5'h0B;
  localparam logic [4:0] FN_XOR     = 5'h0C;

  // ALU operand B selector
  localparam logic [1:0] ASRCB_REG   = 2'b00;
  localparam logic [1:0] ASRCB_ONE   = 2'b01;
  localparam logic [1:0] ASRCB_IMM   = 2'b10;
  localparam logic [1:0] ASRCB_PCREL = 2'b11;

  // PC source selector
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_IMM    = 2'b10;

  typedef enum logic [3:0] {
    S_RST      = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC     = 4'd3,
    S_ALU_WB   = 4'd4,
    S_EXEC_CMP = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_MEM_WB   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_JUMP     = 4'd10,
    S_BRANCH   = 4'd11,
    S_HALT     = 4'd12,
    S_ERROR    = 4'd13
  } state_t;

  typedef enum logic [3:0] {
    CLS_R     = 4'd0,
    CLS_IMM   = 4'd1,
    CLS_CMP   = 4'd2,
    CLS_LOAD  = 4'd3,
    CLS_STORE = 4'd4,
    CLS_JMP   = 4'd5,
    CLS_JZ    = 4'd6,
    CLS_HLT   = 4'd7,
    CLS_ILL   = 4'd8
  } iclass_t;

endpackage
`default_nettype wire

// File: rtl/control_fsm_8085_multi_decode.sv
`default_nettype none
// ============================================================================
//  Module   : instr_class_decode_8085
//  Brief    : Combinational opcode/funct classifier with legality bit.
//  Revision : 1.0  initial release
// ============================================================================
module instr_class_decode_8085
  import pkg_8085_multi::*;
(
  input  logic [4:0] opcode,
  input  logic [4:0] funct,
  output iclass_t    iclass,
  output logic       legal
);

  always_comb begin
    iclass = CLS_ILL;
    legal  = 1'b0;
    if (opcode <= OP_RALU_HI) begin
      iclass = CLS_R;
      legal  = (funct <= FN_ALU_MAX);
    end else if (opcode == OP_RLOG) begin
      iclass = CLS_R;
      legal  = (funct == FN_AND) || (funct == FN_OR) || (funct == FN_XOR);
    end else if ((opcode >= OP_ADI) && (opcode <= OP_IMM_HI)) begin
      iclass = CLS_IMM;
      legal  = 1'b1;
    end else begin
      case (opcode)
        OP_CPI:  begin iclass = CLS_CMP;   legal = 1'b1; end
        OP_LDA:  begin iclass = CLS_LOAD;  legal = 1'b1; end
        OP_STA:  begin iclass = CLS_STORE; legal = 1'b1; end
        OP_JMP:  begin iclass = CLS_JMP;   legal = 1'b1; end
        OP_JZ:   begin iclass = CLS_JZ;    legal = 1'b1; end
        OP_HLT:  begin iclass = CLS_HLT;   legal = 1'b1; end
        default: begin iclass = CLS_ILL;   legal = 1'b0; end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/control_fsm_8085_multi.sv
`default_nettype none
// ============================================================================
//  Module   : control_fsm_8085_multi
//  Brief    : Multi-cycle main control FSM with memory wait-state timeout.
//  Revision : 1.0  initial release
// ============================================================================
module control_fsm_8085_multi
  import pkg_8085_multi::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] opcode,
  input  logic [4:0] funct,
  input  logic       zero_flag,
  input  logic       mem_ready,
  output logic       ALUop,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       flag_write,
  output logic       illegal_op,
  output logic       bus_error,
  output logic       halted
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT_CYCLES);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0] w_wait_cnt_nxt;
  logic             r_illegal;
  logic             r_bus_err;
  logic             w_set_illegal;
  logic             w_set_bus_err;
  logic             w_timeout;
  iclass_t          w_iclass;
  logic             w_legal;
  logic             w_unused;

  // zero_flag qualifies pc_write_cond inside the datapath, not here
  assign w_unused = zero_flag;

  instr_class_decode_8085 u_decode (
    .opcode (opcode),
    .funct  (funct),
    .iclass (w_iclass),
    .legal  (w_legal)
  );

  // The cycle that would take the count to terminal is the last one allowed
  assign w_timeout = !mem_ready && (r_wait_cnt == CNT_LAST);

  assign illegal_op = r_illegal;
  assign bus_error  = r_bus_err;
  assign halted     = (r_state == S_HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_RST;
      r_wait_cnt <= '0;
      r_illegal  <= 1'b0;
      r_bus_err  <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_set_illegal) r_illegal <= 1'b1;
      if (w_set_bus_err) r_bus_err <= 1'b1;
    end
  end

  always_comb begin
    w_wait_cnt_nxt = '0;
    case (r_state)
      S_FETCH, S_MEM_RD, S_MEM_WR: begin
        if (!mem_ready) begin
          w_wait_cnt_nxt = (r_wait_cnt == CNT_TERM) ? r_wait_cnt : r_wait_cnt + CNT_W'(1);
        end
      end
      S_ERROR: w_wait_cnt_nxt = r_wait_cnt;
      default: w_wait_cnt_nxt = '0;
    endcase
  end

  always_comb begin
    w_next        = r_state;
    w_set_illegal = 1'b0;
    w_set_bus_err = 1'b0;
    ALUop         = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = ASRCB_REG;
    pc_src        = PCSRC_ALU;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    flag_write    = 1'b0;

    case (r_state)
      S_RST: w_next = S_FETCH;

      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = ASRCB_ONE;
        ALUop     = 1'b1;
        pc_src    = PCSRC_ALU;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) begin
          w_next = S_DECODE;
        end else if (w_timeout) begin
          w_next        = S_ERROR;
          w_set_bus_err = 1'b1;
        end
      end

      S_DECODE: begin
        alu_src_b = ASRCB_PCREL;
        ALUop     = 1'b1;
        if (!w_legal) begin
          w_next        = S_ERROR;
          w_set_illegal = 1'b1;
        end else begin
          case (w_iclass)
            CLS_R, CLS_IMM:      w_next = S_EXEC;
            CLS_CMP:             w_next = S_EXEC_CMP;
            CLS_LOAD, CLS_STORE: w_next = S_MEM_ADDR;
            CLS_JMP:             w_next = S_JUMP;
            CLS_JZ:              w_next = S_BRANCH;
            CLS_HLT:             w_next = S_HALT;
            default: begin
              w_next        = S_ERROR;
              w_set_illegal = 1'b1;
            end
          endcase
        end
      end

      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = (w_iclass == CLS_IMM) ? ASRCB_IMM : ASRCB_REG;
        w_next    = S_ALU_WB;
      end

      S_ALU_WB: begin
        reg_write  = 1'b1;
        flag_write = 1'b1;
        w_next     = S_FETCH;
      end

      S_EXEC_CMP: begin
        alu_src_a  = 1'b1;
        alu_src_b  = ASRCB_IMM;
        flag_write = 1'b1;
        w_next     = S_FETCH;
      end

      S_MEM_ADDR: begin
        ALUop     = 1'b1;
        alu_src_a = 1'b1;
        alu_src_b = ASRCB_IMM;
        w_next    = (w_iclass == CLS_LOAD) ? S_MEM_RD : S_MEM_WR;
      end

      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) begin
          w_next = S_MEM_WB;
        end else if (w_timeout) begin
          w_next        = S_ERROR;
          w_set_bus_err = 1'b1;
        end
      end

      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        w_next     = S_FETCH;
      end

      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) begin
          w_next = S_FETCH;
        end else if (w_timeout) begin
          w_next        = S_ERROR;
          w_set_bus_err = 1'b1;
        end
      end

      S_JUMP: begin
        pc_src   = PCSRC_IMM;
        pc_write = 1'b1;
        w_next   = S_FETCH;
      end

      S_BRANCH: begin
        pc_src        = PCSRC_ALUOUT;
        pc_write_cond = 1'b1;
        w_next        = S_FETCH;
      end

      S_HALT:  w_next = S_HALT;
      S_ERROR: w_next = S_ERROR;
      default: w_next = S_RST;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_control_fsm_8085_multi.sv
`default_nettype none
// ============================================================================
//  Module   : tb_control_fsm_8085_multi
//  Brief    : Instruction-level expected-trace bench for the control FSM.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_control_fsm_8085_multi;

  localparam int X = -1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] opcode = 5'h00;
  logic [4:0] funct = 5'h00;
  logic       zero_flag = 1'b0;
  logic       mem_ready = 1'b0;
  logic       ALUop, alu_src_a, pc_write, pc_write_cond, ir_write, mem_read, mem_write;
  logic       i_or_d, reg_write, mem_to_reg, flag_write, illegal_op, bus_error, halted;
  logic [1:0] alu_src_b, pc_src;

  always #5 clk = ~clk;

  control_fsm_8085_multi #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero_flag(zero_flag),
    .mem_ready(mem_ready), .ALUop(ALUop), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_src(pc_src), .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
    .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .flag_write(flag_write), .illegal_op(illegal_op),
    .bus_error(bus_error), .halted(halted)
  );

  // 17 ALUop,16 src_a,15:14 src_b,13:12 pc_src,11 pc_write,10 pc_write_cond,9 ir_write,
  // 8 mem_read,7 mem_write,6 i_or_d,5 reg_write,4 mem_to_reg,3 flag_write,2 ill,1 bus,0 halt
  logic [17:0] got;
  assign got = {ALUop, alu_src_a, alu_src_b, pc_src, pc_write, pc_write_cond, ir_write,
                mem_read, mem_write, i_or_d, reg_write, mem_to_reg, flag_write,
                illegal_op, bus_error, halted};

  typedef struct {
    string       tag;
    bit          rdy;
    bit          zf;
    logic [4:0]  op;
    logic [4:0]  fn;
    logic [17:0] exp;
    logic [17:0] care;
  } cyc_t;

  cyc_t       q[$];
  int         checks = 0;
  int         failures = 0;
  logic [4:0] cur_op = 5'h00;
  logic [4:0] cur_fn = 5'h00;
  bit         cur_zf = 1'b0;

  // One expected cycle; X on a select field means the state does not define it
  function automatic void push(string tag, bit rdy, int aluop, int asa, int asb, int pcs, int iod,
                               bit pcw, bit pcwc, bit irw, bit mr, bit mw, bit rw, bit m2r,
                               bit fw, bit ill, bit be, bit hl);
    cyc_t c;
    c.tag = tag; c.rdy = rdy; c.zf = cur_zf; c.op = cur_op; c.fn = cur_fn;
    c.care = '1;
    c.exp  = '0;
    if (aluop < 0) c.care[17] = 1'b0;    else c.exp[17] = aluop[0];
    if (asa < 0)   c.care[16] = 1'b0;    else c.exp[16] = asa[0];
    if (asb < 0)   c.care[15:14] = 2'b0; else c.exp[15:14] = asb[1:0];
    if (pcs < 0)   c.care[13:12] = 2'b0; else c.exp[13:12] = pcs[1:0];
    if (iod < 0)   c.care[6] = 1'b0;     else c.exp[6] = iod[0];
    c.exp[11:7] = {pcw, pcwc, irw, mr, mw};
    c.exp[5:0]  = {rw, m2r, fw, ill, be, hl};
    q.push_back(c);
  endfunction

  function automatic void instr(logic [4:0] op, logic [4:0] fn, bit zf);
    cur_op = op; cur_fn = fn; cur_zf = zf;
  endfunction

  function automatic void rst_cycle();
    push("S_RST", 1'b0, 0, 0, 0, 0, 0, 0,0,0,0,0,0,0,0, 0,0,0);
  endfunction
  function automatic void fetch_wait(int n);
    for (int i = 0; i < n; i++) push("FETCH_wait", 1'b0, 1, 0, 1, 0, 0, 0,0,0,1,0,0,0,0, 0,0,0);
  endfunction
  function automatic void fetch(int waits);
    fetch_wait(waits);
    push("FETCH", 1'b1, 1, 0, 1, 0, 0, 1,0,1,1,0,0,0,0, 0,0,0);
  endfunction
  function automatic void decode();
    push("DECODE", 1'b0, 1, 0, 3, X, X, 0,0,0,0,0,0,0,0, 0,0,0);
  endfunction
  function automatic void exec(bit imm);
    push(imm ? "EXEC_imm" : "EXEC_r", 1'b0, 0, 1, imm ? 2 : 0, X, X, 0,0,0,0,0,0,0,0, 0,0,0);
  endfunction
  function automatic void alu_wb();
    push("ALU_WB", 1'b0, 0, X, X, X, X, 0,0,0,0,0,1,0,1, 0,0,0);
  endfunction
  function automatic void exec_cmp();
    push("EXEC_CMP", 1'b0, 0, 1, 2, X, X, 0,0,0,0,0,0,0,1, 0,0,0);
  endfunction
  function automatic void mem_addr();
    push("MEM_ADDR", 1'b0, 1, 1, 2, X, X, 0,0,0,0,0,0,0,0, 0,0,0);
  endfunction
  function automatic void mem_rd(int waits);
    for (int i = 0; i < waits; i++) push("MEM_RD_wait", 1'b0, X, X, X, X, 1, 0,0,0,1,0,0,0,0, 0,0,0);
    push("MEM_RD", 1'b1, X, X, X, X, 1, 0,0,0,1,0,0,0,0, 0,0,0);
  endfunction
  function automatic void mem_wb();
    push("MEM_WB", 1'b0, X, X, X, X, X, 0,0,0,0,0,1,1,0, 0,0,0);
  endfunction
  function automatic void mem_wr_wait(int n);
    for (int i = 0; i < n; i++) push("MEM_WR_wait", 1'b0, X, X, X, X, 1, 0,0,0,0,1,0,0,0, 0,0,0);
  endfunction
  function automatic void mem_wr(int waits);
    mem_wr_wait(waits);
    push("MEM_WR", 1'b1, X, X, X, X, 1, 0,0,0,0,1,0,0,0, 0,0,0);
  endfunction
  function automatic void jump();
    push("JUMP", 1'b0, X, X, X, 2, X, 1,0,0,0,0,0,0,0, 0,0,0);
  endfunction
  function automatic void branch();
    push("BRANCH", 1'b0, X, X, X, 1, X, 0,1,0,0,0,0,0,0, 0,0,0);
  endfunction
  function automatic void error(int n, bit ill, bit be);
    for (int i = 0; i < n; i++) push("ERROR", i[0], X, X, X, X, 0, 0,0,0,0,0,0,0,0, ill,be,0);
  endfunction
  function automatic void halt(int n);
    for (int i = 0; i < n; i++) push("HALT", i[0], X, X, X, X, 0, 0,0,0,0,0,0,0,0, 0,0,1);
  endfunction

  task automatic check_bit(string name, logic act, logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %b required %b", name, act, req);
    end
  endtask

  task automatic check_vec(string name, logic [17:0] act, logic [17:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Compare process: apply each cycle's inputs at the falling edge, check mid-low-phase
  task automatic run();
    cyc_t c;
    while (q.size() > 0) begin
      c = q.pop_front();
      mem_ready = c.rdy; zero_flag = c.zf; opcode = c.op; funct = c.fn;
      #2;
      checks++;
      if ((got & c.care) !== (c.exp & c.care)) begin
        failures++;
        $display("FAIL %s: got %h required %h (mask %h)", c.tag, got & c.care, c.exp & c.care, c.care);
      end
      checks++;
      if (mem_write && (mem_read || reg_write)) begin
        failures++;
        $display("FAIL %s_exclusive: mem_write=%b mem_read=%b reg_write=%b required no overlap",
                 c.tag, mem_write, mem_read, reg_write);
      end
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; mem_ready = 1'b0;
    #2;
    check_vec("reset_outputs", got, 18'h00000);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Straight-line instruction mix without resets between instructions
    do_reset();
    rst_cycle();
    instr(5'h00, 5'h00, 0); fetch(0); decode(); exec(0); alu_wb();
    instr(5'h03, 5'h09, 0); fetch(2); decode(); exec(0); alu_wb();
    instr(5'h04, 5'h0B, 0); fetch(0); decode(); exec(0); alu_wb();
    instr(5'h05, 5'h1F, 0); fetch(0); decode(); exec(1); alu_wb();
    instr(5'h0B, 5'h00, 0); fetch(1); decode(); exec(1); alu_wb();
    instr(5'h0C, 5'h00, 0); fetch(0); decode(); exec_cmp();
    instr(5'h0F, 5'h00, 0); fetch(0); decode(); mem_addr(); mem_rd(3); mem_wb();
    instr(5'h0F, 5'h00, 0); fetch(15); decode(); mem_addr(); mem_rd(15); mem_wb();
    instr(5'h10, 5'h00, 0); fetch(0); decode(); mem_addr(); mem_wr(2);
    instr(5'h11, 5'h00, 0); fetch(0); decode(); jump();
    instr(5'h12, 5'h00, 0); fetch(0); decode(); branch();
    instr(5'h12, 5'h00, 1); fetch(0); decode(); branch();
    instr(5'h0D, 5'h00, 0); fetch(0); decode(); error(5, 1, 0);
    run();
    check_bit("illegal_sticky", illegal_op, 1'b1);

    // Bad funct on R-logic
    do_reset();
    rst_cycle();
    instr(5'h04, 5'h00, 0); fetch(0); decode(); error(4, 1, 0);
    run();

    // Funct one past the R-ALU range
    do_reset();
    rst_cycle();
    instr(5'h00, 5'h0A, 0); fetch(0); decode(); error(3, 1, 0);
    run();

    // STA with memory never ready
    do_reset();
    rst_cycle();
    instr(5'h10, 5'h00, 0); fetch(0); decode(); mem_addr(); mem_wr_wait(16); error(6, 0, 1);
    run();
    check_bit("bus_error_sticky", bus_error, 1'b1);

    // Instruction fetch that never completes
    do_reset();
    rst_cycle();
    instr(5'h00, 5'h00, 0); fetch_wait(16); error(3, 0, 1);
    run();

    // Halt holds for 100 cycles
    do_reset();
    rst_cycle();
    instr(5'h1F, 5'h00, 0); fetch(0); decode(); halt(100);
    run();
    check_bit("halted_after_100", halted, 1'b1);

    // Asynchronous reset in the middle of a store
    do_reset();
    rst_cycle();
    instr(5'h10, 5'h00, 0); fetch(0); decode(); mem_addr(); mem_wr_wait(3);
    run();
    check_bit("mem_write_before_reset", mem_write, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    check_bit("mem_write_async_drop", mem_write, 1'b0);
    check_vec("async_reset_outputs", got, 18'h00000);
    @(negedge clk);
    rst_n = 1'b1;
    rst_cycle();
    fetch(0);
    run();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
